// File: rtl/mem_stage_pkg.sv
// Purpose : shared types and helpers for the memory-stage access unit.
// Latency : n/a (types, constants, one combinational helper).
// Backpr. : n/a.
// Contents: mem_state_t FSM encoding, access-size codes SZ_*, calc_wstrb().
package mem_stage_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_DRAIN
    } mem_state_t;

    // log2 of the access size in bytes
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Byte strobes for an access of 2**size bytes starting at byte lane 'lane'.
    // Returned wide enough for any 64-bit lane/size pair; the caller truncates
    // to its strobe width, which drops bytes that fall past the word boundary.
    function automatic logic [15:0] calc_wstrb(input logic [1:0] size,
                                               input logic [2:0] lane);
        logic [15:0] base;
        case (size)
            SZ_B:    base = 16'h0001;
            SZ_H:    base = 16'h0003;
            SZ_W:    base = 16'h000F;
            default: base = 16'h00FF;
        endcase
        return base << lane;
    endfunction

endpackage

// File: rtl/mem_load_formatter.sv
// Purpose : extracts a load result from an aligned cache word (shift, mask, extend).
// Latency : purely combinational.
// Backpr. : none; output follows inputs.
// Ports   : rdata (cache word), lane (byte offset), size (log2 bytes),
//           is_unsigned (zero-extend), data (formatted result).
module mem_load_formatter
    import mem_stage_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int LANE_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]   rdata,
    input  logic [LANE_W-1:0] lane,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    output logic [XLEN-1:0]   data
);

    logic [XLEN-1:0] ones;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic            sign;

    // Bytes past the top of the word shift in as zero, so a straddling access
    // reads them as 0. A size wider than the word (D on a 32-bit datapath)
    // falls to the full-width default, i.e. behaves as W.
    always_comb begin
        ones    = '1;
        shifted = rdata >> {lane, 3'b000};
        mask    = ones;
        sign    = shifted[XLEN-1];
        case (size)
            SZ_B: begin
                mask = ones >> (XLEN - 8);
                sign = shifted[7];
            end
            SZ_H: begin
                mask = ones >> (XLEN - 16);
                sign = shifted[15];
            end
            SZ_W: begin
                mask = ones >> (XLEN - 32);
                sign = shifted[31];
            end
            default: ;
        endcase
        data = (shifted & mask) | ((sign && !is_unsigned) ? ~mask : '0);
    end

endmodule

// File: rtl/mem_stage_access_unit.sv
// Purpose : MEM-stage controller: one entry at a time, issues dcache load/store, formats result.
// Latency : load/store in_valid->out_valid 3 cycles with zero-wait cache; non-memory 1 cycle.
// Backpr. : in_ready only in IDLE or HOLD&&out_ready; request held until dc_req_ready; result held until out_ready.
// Ports   : clk/reset (async, active high); in_* EX/MEM entry (valid/ready); flush kills entry;
//           dc_req_* cache request (valid/ready); dc_resp_* cache response; out_* MEM/WB result (valid/ready).
// Option  : define MISALIGN_TRAP_EN to trap misaligned accesses (no request, out_misaligned=1).
module mem_stage_access_unit
    import mem_stage_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64,
    parameter int STRB_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_read,
    input  logic              in_write,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [XLEN-1:0]   in_store_data,
    input  logic              flush,
    output logic              dc_req_valid,
    input  logic              dc_req_ready,
    output logic              dc_req_write,
    output logic [ADDR_W-1:0] dc_req_addr,
    output logic [XLEN-1:0]   dc_req_wdata,
    output logic [STRB_W-1:0] dc_req_wstrb,
    input  logic              dc_resp_valid,
    input  logic [XLEN-1:0]   dc_resp_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_load_data,
    output logic              out_misaligned
);

    localparam int LANE_W = $clog2(STRB_W);

    mem_state_t        state_q, state_d;
    logic              read_q, read_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic              req_write_q, req_write_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [XLEN-1:0]   req_wdata_q, req_wdata_d;
    logic [STRB_W-1:0] req_wstrb_q, req_wstrb_d;
    logic [XLEN-1:0]   load_data_q, load_data_d;
    logic              misaligned_q, misaligned_d;

    logic [LANE_W-1:0] in_lane;
    logic [1:0]        in_eff_size;
    logic              in_is_mem;
    logic              in_mis;
    logic              accept;
    logic              take_entry;
    logic [XLEN-1:0]   fmt_data;

    assign in_lane     = in_addr[LANE_W-1:0];
    // a doubleword on a 32-bit datapath is handled as a word
    assign in_eff_size = (XLEN == 32 && in_size == SZ_D) ? SZ_W : in_size;
    assign in_is_mem   = in_read | in_write;

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        case (in_eff_size)
            SZ_H:    in_mis = in_addr[0];
            SZ_W:    in_mis = |in_addr[1:0];
            SZ_D:    in_mis = |in_addr[2:0];
            default: in_mis = 1'b0;
        endcase
    end
`else
    assign in_mis = 1'b0;
`endif

    // HOLD can hand its slot to a new entry in the same cycle MEM/WB takes the
    // result; flush wins over out_ready, so it also blocks that acceptance.
    assign in_ready = (state_q == ST_IDLE) ||
                      (state_q == ST_HOLD && out_ready && !flush);
    assign accept   = in_valid && in_ready && !flush;

    mem_load_formatter #(
        .XLEN   (XLEN),
        .LANE_W (LANE_W)
    ) u_fmt (
        .rdata       (dc_resp_rdata),
        .lane        (lane_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .data        (fmt_data)
    );

    always_comb begin
        state_d      = state_q;
        read_d       = read_q;
        size_d       = size_q;
        uns_d        = uns_q;
        lane_d       = lane_q;
        req_write_d  = req_write_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        req_wstrb_d  = req_wstrb_q;
        load_data_d  = load_data_q;
        misaligned_d = misaligned_q;
        take_entry   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) take_entry = 1'b1;
            end
            ST_REQ: begin
                // once the cache has taken the request its response must be
                // swallowed, hence DRAIN rather than IDLE on a handshake flush
                if (flush)             state_d = dc_req_ready ? ST_DRAIN : ST_IDLE;
                else if (dc_req_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (flush) begin
                    // response arriving with the flush is already the one to discard
                    state_d = dc_resp_valid ? ST_IDLE : ST_DRAIN;
                end else if (dc_resp_valid) begin
                    state_d     = ST_HOLD;
                    load_data_d = read_q ? fmt_data : '0;
                end
            end
            ST_HOLD: begin
                if (flush)          state_d = ST_IDLE;
                else if (out_ready) begin
                    if (accept) take_entry = 1'b1;
                    else        state_d    = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (dc_resp_valid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (take_entry) begin
            read_d       = in_read;
            size_d       = in_eff_size;
            uns_d        = in_unsigned;
            lane_d       = in_lane;
            req_write_d  = in_write && !in_read;
            req_addr_d   = {in_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
            req_wdata_d  = in_store_data << {in_lane, 3'b000};
            req_wstrb_d  = STRB_W'(calc_wstrb(in_eff_size, 3'(in_lane)));
            load_data_d  = '0;
            misaligned_d = in_is_mem && in_mis;
            state_d      = (in_is_mem && !in_mis) ? ST_REQ : ST_HOLD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            read_q       <= 1'b0;
            size_q       <= SZ_B;
            uns_q        <= 1'b0;
            lane_q       <= '0;
            req_write_q  <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            req_wstrb_q  <= '0;
            load_data_q  <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            read_q       <= read_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            lane_q       <= lane_d;
            req_write_q  <= req_write_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            req_wstrb_q  <= req_wstrb_d;
            load_data_q  <= load_data_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign dc_req_valid   = (state_q == ST_REQ);
    assign dc_req_write   = req_write_q;
    assign dc_req_addr    = req_addr_q;
    assign dc_req_wdata   = req_wdata_q;
    assign dc_req_wstrb   = req_wstrb_q;
    assign out_valid      = (state_q == ST_HOLD);
    assign out_load_data  = load_data_q;
    assign out_misaligned = misaligned_q;

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Purpose : directed self-checking bench for mem_stage_access_unit (XLEN=64).
// Latency : n/a.
// Backpr. : cache and MEM/WB handshakes driven cycle by cycle from the stimulus.
module tb_mem_stage_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_read = 1'b0;
    logic        in_write = 1'b0;
    logic [1:0]  in_size = 2'd0;
    logic        in_unsigned = 1'b0;
    logic [63:0] in_addr = '0;
    logic [63:0] in_store_data = '0;
    logic        flush = 1'b0;
    logic        dc_req_valid;
    logic        dc_req_ready = 1'b0;
    logic        dc_req_write;
    logic [63:0] dc_req_addr;
    logic [63:0] dc_req_wdata;
    logic [7:0]  dc_req_wstrb;
    logic        dc_resp_valid = 1'b0;
    logic [63:0] dc_resp_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_load_data;
    logic        out_misaligned;

    int n_vec  = 0;
    int n_miss = 0;

    // bytes: b7..b0 = 12 34 FF 80 00 AB CD EF
    localparam logic [63:0] WORD1 = 64'h1234_FF80_00AB_CDEF;

    mem_stage_access_unit #(.XLEN(64), .ADDR_W(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_read        (in_read),
        .in_write       (in_write),
        .in_size        (in_size),
        .in_unsigned    (in_unsigned),
        .in_addr        (in_addr),
        .in_store_data  (in_store_data),
        .flush          (flush),
        .dc_req_valid   (dc_req_valid),
        .dc_req_ready   (dc_req_ready),
        .dc_req_write   (dc_req_write),
        .dc_req_addr    (dc_req_addr),
        .dc_req_wdata   (dc_req_wdata),
        .dc_req_wstrb   (dc_req_wstrb),
        .dc_resp_valid  (dc_resp_valid),
        .dc_resp_rdata  (dc_resp_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_load_data  (out_load_data),
        .out_misaligned (out_misaligned)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_entry(input logic rd, input logic wr, input logic [1:0] sz,
                               input logic uns, input logic [63:0] addr, input logic [63:0] sdata);
        in_valid      = 1'b1;
        in_read       = rd;
        in_write      = wr;
        in_size       = sz;
        in_unsigned   = uns;
        in_addr       = addr;
        in_store_data = sdata;
    endtask

    task automatic clear_entry();
        in_valid      = 1'b0;
        in_read       = 1'b0;
        in_write      = 1'b0;
        in_addr       = '1;
        in_store_data = '1;
    endtask

    // Full load with zero-wait cache; result held 'hold' extra cycles with out_ready low.
    task automatic do_load(input string tag, input logic [63:0] addr, input logic [1:0] sz,
                           input logic uns, input logic [63:0] word, input logic [63:0] exp,
                           input int hold);
        drive_entry(1'b1, 1'b0, sz, uns, addr, 64'h5555_5555_5555_5555);
        settle();
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        tick();
        clear_entry();
        dc_req_ready = 1'b1;
        settle();
        chk({tag, "_req_vld"}, dc_req_valid, 1'b1);
        chk({tag, "_req_addr"}, dc_req_addr, {addr[63:3], 3'b000});
        tick();
        dc_req_ready  = 1'b0;
        dc_resp_valid = 1'b1;
        dc_resp_rdata = word;
        settle();
        chk({tag, "_no_out_yet"}, out_valid, 1'b0);
        tick();
        dc_resp_valid = 1'b0;
        dc_resp_rdata = '0;
        for (int i = 0; i < hold; i++) begin
            settle();
            chk({tag, "_hold_vld"}, out_valid, 1'b1);
            chk({tag, "_hold_data"}, out_load_data, exp);
            tick();
        end
        out_ready = 1'b1;
        settle();
        chk({tag, "_out_vld"}, out_valid, 1'b1);
        chk({tag, "_data"}, out_load_data, exp);
        tick();
        out_ready = 1'b0;
        settle();
        chk({tag, "_done"}, out_valid, 1'b0);
    endtask

    // Full store; dc_req_ready held low for 'stall' cycles first.
    task automatic do_store(input string tag, input logic [63:0] addr, input logic [1:0] sz,
                            input logic [63:0] sdata, input logic [63:0] exp_addr,
                            input logic [63:0] exp_wdata, input logic [7:0] exp_wstrb,
                            input int stall);
        drive_entry(1'b0, 1'b1, sz, 1'b0, addr, sdata);
        settle();
        tick();
        clear_entry();
        dc_req_ready = 1'b0;
        for (int i = 0; i <= stall; i++) begin
            if (i == stall) dc_req_ready = 1'b1;
            settle();
            chk({tag, "_req_vld"}, dc_req_valid, 1'b1);
            chk({tag, "_req_wr"}, dc_req_write, 1'b1);
            chk({tag, "_req_addr"}, dc_req_addr, exp_addr);
            chk({tag, "_wdata"}, dc_req_wdata, exp_wdata);
            chk({tag, "_wstrb"}, dc_req_wstrb, exp_wstrb);
            tick();
        end
        dc_req_ready  = 1'b0;
        dc_resp_valid = 1'b1;
        settle();
        chk({tag, "_no_out_yet"}, out_valid, 1'b0);
        tick();
        dc_resp_valid = 1'b0;
        out_ready     = 1'b1;
        settle();
        chk({tag, "_out_vld"}, out_valid, 1'b1);
        chk({tag, "_out_data0"}, out_load_data, 64'h0);
        tick();
        out_ready = 1'b0;
        settle();
        chk({tag, "_done"}, out_valid, 1'b0);
    endtask

    initial begin
        // ---------------- reset values ----------------
        #1 reset = 1'b1;
        settle();
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_req_vld", dc_req_valid, 1'b0);
        chk("rst_out_vld", out_valid, 1'b0);
        chk("rst_load_data", out_load_data, 64'h0);
        chk("rst_misaligned", out_misaligned, 1'b0);
        chk("rst_req_addr", dc_req_addr, 64'h0);
        chk("rst_wdata", dc_req_wdata, 64'h0);
        chk("rst_wstrb", dc_req_wstrb, 8'h0);
        tick();
        tick();
        reset = 1'b0;
        settle();

        // ---------------- loads ----------------
        do_load("lb_1003", 64'h1003, 2'd0, 1'b0, WORD1, 64'h0, 0);
        do_load("lb_1005", 64'h1005, 2'd0, 1'b0, WORD1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        do_load("lhu_1006", 64'h1006, 2'd1, 1'b1, WORD1, 64'h1234, 0);
        do_load("lh_1004", 64'h1004, 2'd1, 1'b0, WORD1, 64'hFFFF_FFFF_FFFF_FF80, 0);
        do_load("lbu_1004", 64'h1004, 2'd0, 1'b1, WORD1, 64'h80, 0);
        do_load("lw_1000", 64'h1000, 2'd2, 1'b0, WORD1, 64'h00AB_CDEF, 0);
        do_load("lw_1004", 64'h1004, 2'd2, 1'b0, 64'h8000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001, 0);
        do_load("ld_hold3", 64'h1000, 2'd3, 1'b0, WORD1, WORD1, 3);

        // ---------------- non-memory, back-to-back into a load ----------------
        out_ready = 1'b1;
        drive_entry(1'b0, 1'b0, 2'd0, 1'b0, 64'h40, 64'h0);
        settle();
        chk("nm_in_ready", in_ready, 1'b1);
        tick();
        settle();
        chk("nm_a_out_vld", out_valid, 1'b1);
        chk("nm_a_no_req", dc_req_valid, 1'b0);
        chk("nm_a_data0", out_load_data, 64'h0);
        chk("nm_b2b_in_ready", in_ready, 1'b1);
        tick();
        drive_entry(1'b1, 1'b0, 2'd1, 1'b1, 64'h1006, 64'h0);
        settle();
        chk("nm_b_out_vld", out_valid, 1'b1);
        chk("nm_b_no_req", dc_req_valid, 1'b0);
        chk("nm_b_in_ready", in_ready, 1'b1);
        tick();
        clear_entry();
        out_ready    = 1'b0;
        dc_req_ready = 1'b1;
        settle();
        chk("b2b_ld_req_vld", dc_req_valid, 1'b1);
        chk("b2b_ld_no_out", out_valid, 1'b0);
        tick();
        dc_req_ready  = 1'b0;
        dc_resp_valid = 1'b1;
        dc_resp_rdata = WORD1;
        tick();
        dc_resp_valid = 1'b0;
        out_ready     = 1'b1;
        settle();
        chk("b2b_ld_out_vld", out_valid, 1'b1);
        chk("b2b_ld_data", out_load_data, 64'h1234);
        tick();
        out_ready = 1'b0;
        settle();

        // ---------------- stores ----------------
        do_store("sw_2004", 64'h2004, 2'd2, 64'hDEAD_BEEF, 64'h2000,
                 64'hDEAD_BEEF_0000_0000, 8'hF0, 5);
        do_store("sh_3006", 64'h3006, 2'd1, 64'hABCD, 64'h3000,
                 64'hABCD_0000_0000_0000, 8'hC0, 0);
        do_store("sb_3007", 64'h3007, 2'd0, 64'hFFFF_FFFF_FFFF_FF11, 64'h3000,
                 64'h1100_0000_0000_0000, 8'h80, 1);
        do_store("sd_4008", 64'h4008, 2'd3, 64'h0123_4567_89AB_CDEF, 64'h4008,
                 64'h0123_4567_89AB_CDEF, 8'hFF, 0);

        // ---------------- flush in IDLE ----------------
        drive_entry(1'b1, 1'b0, 2'd0, 1'b0, 64'h1000, 64'h0);
        flush = 1'b1;
        settle();
        tick();
        clear_entry();
        flush = 1'b0;
        settle();
        chk("fl_idle_no_req", dc_req_valid, 1'b0);
        chk("fl_idle_no_out", out_valid, 1'b0);

        // ---------------- flush in REQ before handshake ----------------
        drive_entry(1'b1, 1'b0, 2'd0, 1'b0, 64'h1000, 64'h0);
        settle();
        tick();
        clear_entry();
        flush = 1'b1;
        settle();
        chk("fl_req_vld_pre", dc_req_valid, 1'b1);
        tick();
        flush = 1'b0;
        settle();
        chk("fl_req_dropped", dc_req_valid, 1'b0);
        chk("fl_req_idle", in_ready, 1'b1);
        chk("fl_req_no_out", out_valid, 1'b0);

        // ---------------- flush in HOLD beats out_ready ----------------
        drive_entry(1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0);
        settle();
        tick();
        clear_entry();
        flush     = 1'b1;
        out_ready = 1'b1;
        settle();
        chk("fl_hold_vld", out_valid, 1'b1);
        chk("fl_hold_in_ready", in_ready, 1'b0);
        tick();
        flush     = 1'b0;
        out_ready = 1'b0;
        settle();
        chk("fl_hold_dropped", out_valid, 1'b0);

        // ---------------- flush in WAIT, late response drained ----------------
        drive_entry(1'b1, 1'b0, 2'd3, 1'b0, 64'h1000, 64'h0);
        settle();
        tick();
        clear_entry();
        dc_req_ready = 1'b1;
        settle();
        tick();
        dc_req_ready = 1'b0;
        flush        = 1'b1;
        settle();
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("drain_no_out", out_valid, 1'b0);
            chk("drain_in_ready", in_ready, 1'b0);
            tick();
        end
        dc_resp_valid = 1'b1;
        dc_resp_rdata = 64'hAA;
        settle();
        tick();
        dc_resp_valid = 1'b0;
        dc_resp_rdata = '0;
        settle();
        chk("drain_discard", out_valid, 1'b0);
        chk("drain_idle", in_ready, 1'b1);
        do_load("after_drain", 64'h1005, 2'd0, 1'b0, WORD1, 64'hFFFF_FFFF_FFFF_FFFF, 0);

        // ---------------- reset in WAIT ----------------
        drive_entry(1'b1, 1'b0, 2'd2, 1'b0, 64'h5004, 64'h0);
        settle();
        tick();
        clear_entry();
        dc_req_ready = 1'b1;
        settle();
        chk("rw_req_addr", dc_req_addr, 64'h5000);
        tick();
        dc_req_ready = 1'b0;
        reset        = 1'b1;
        settle();
        chk("rw_req_vld", dc_req_valid, 1'b0);
        chk("rw_req_addr0", dc_req_addr, 64'h0);
        chk("rw_out_vld", out_valid, 1'b0);
        chk("rw_load_data0", out_load_data, 64'h0);
        chk("rw_in_ready", in_ready, 1'b1);
        tick();
        reset         = 1'b0;
        dc_resp_valid = 1'b1;
        dc_resp_rdata = 64'hFFFF_0000_FFFF_0000;
        settle();
        tick();
        dc_resp_valid = 1'b0;
        settle();
        chk("rw_late_resp_ignored", out_valid, 1'b0);
        chk("rw_late_resp_data", out_load_data, 64'h0);

`ifdef MISALIGN_TRAP_EN
        // ---------------- misaligned trap ----------------
        drive_entry(1'b1, 1'b0, 2'd1, 1'b0, 64'h1001, 64'h0);
        settle();
        tick();
        clear_entry();
        settle();
        chk("mis_out_vld", out_valid, 1'b1);
        chk("mis_flag", out_misaligned, 1'b1);
        chk("mis_no_req", dc_req_valid, 1'b0);
        chk("mis_data0", out_load_data, 64'h0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        settle();
        chk("mis_done", out_valid, 1'b0);
`else
        // ---------------- straddling access: upper bytes dropped ----------------
        do_load("lh_1007_straddle", 64'h1007, 2'd1, 1'b0, 64'h9200_0000_0000_0000, 64'h92, 0);
        chk("straddle_no_mis", out_misaligned, 1'b0);
        do_store("sh_1007_straddle", 64'h1007, 2'd1, 64'hBBAA, 64'h1000,
                 64'hAA00_0000_0000_0000, 8'h80, 0);
`endif

        // ---------------- response outside WAIT/DRAIN ----------------
        dc_resp_valid = 1'b1;
        dc_resp_rdata = 64'h77;
        settle();
        tick();
        dc_resp_valid = 1'b0;
        settle();
        chk("idle_resp_ignored", out_valid, 1'b0);
        chk("idle_resp_in_ready", in_ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
